// File: rtl/debug_access_sequencer.sv
// debug_access_sequencer: drives the SystemTest debug inputs from a valid/ready command channel.
// Sequences memory/register accesses (with write-verify) and bounded RUN sessions reporting the final PC.
module debug_access_sequencer #(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 16,
  parameter int unsigned RAW         = 4,
  parameter int unsigned SW          = 9,
  parameter int unsigned FETCH_STATE = 1,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TW          = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [AW-1:0]  cmd_addr,
  input  logic [DW-1:0]  cmd_data,
  input  logic [15:0]    cmd_count,
  input  logic [TW-1:0]  cmd_timeout,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_data,
  output logic [1:0]     rsp_status,
  output logic           dut_reset,
  output logic           test,
  output logic           memoryoperation,
  output logic           registeroperation,
  output logic           memorywrite,
  output logic           registerwrite,
  output logic [AW-1:0]  memaddress,
  output logic [DW-1:0]  memwritedata,
  output logic [AW-1:0]  resetpc,
  output logic [RAW-1:0] registeraddress,
  output logic [DW-1:0]  regwritedata,
  input  logic [DW-1:0]  RD,
  input  logic [DW-1:0]  MD,
  input  logic [DW-1:0]  PC,
  input  logic [SW-1:0]  state
);

  localparam int unsigned WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);
  localparam logic [SW-1:0]  FETCH_ENC = SW'(FETCH_STATE);

  localparam logic [2:0] OP_WR_REG = 3'd3;
  localparam logic [2:0] OP_RUN    = 3'd4;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_VERIFY  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RUN_RST, S_RUN, S_RESP} fsm_t;

  fsm_t           r_state, w_state;
  logic           r_is_mem, w_is_mem;
  logic           r_is_write, w_is_write;
  logic [WCW-1:0] r_wait, w_wait;
  logic [16:0]    r_remaining, w_remaining;
  logic [TW-1:0]  r_cycle, w_cycle;
  logic [TW-1:0]  r_timeout, w_timeout;
  logic           r_prev_fetch, w_prev_fetch;
  logic           r_cmd_ready, r_rsp_valid;
  logic [DW-1:0]  r_rsp_data, w_rsp_data;
  logic [1:0]     r_rsp_status, w_rsp_status;
  logic           r_dut_reset, w_dut_reset;
  logic           r_test, w_test;
  logic           r_memop, w_memop;
  logic           r_regop, w_regop;
  logic           r_memwr, w_memwr;
  logic           r_regwr, w_regwr;
  logic [AW-1:0]  r_memaddr, w_memaddr;
  logic [DW-1:0]  r_memwdata, w_memwdata;
  logic [AW-1:0]  r_resetpc, w_resetpc;
  logic [RAW-1:0] r_regaddr, w_regaddr;
  logic [DW-1:0]  r_regwdata, w_regwdata;
  logic [DW-1:0]  w_sample;
  logic           w_fetch;

  // Next-state and next-output logic; every register holds unless a transition updates it.
  always_comb begin
    w_state      = r_state;
    w_is_mem     = r_is_mem;
    w_is_write   = r_is_write;
    w_wait       = r_wait;
    w_remaining  = r_remaining;
    w_cycle      = r_cycle;
    w_timeout    = r_timeout;
    w_rsp_data   = r_rsp_data;
    w_rsp_status = r_rsp_status;
    w_dut_reset  = 1'b0;
    w_test       = r_test;
    w_memop      = r_memop;
    w_regop      = r_regop;
    w_memwr      = r_memwr;
    w_regwr      = r_regwr;
    w_memaddr    = r_memaddr;
    w_memwdata   = r_memwdata;
    w_resetpc    = r_resetpc;
    w_regaddr    = r_regaddr;
    w_regwdata   = r_regwdata;
    w_sample     = r_is_mem ? MD : RD;
    w_fetch      = (state == FETCH_ENC) && !r_prev_fetch;
    w_prev_fetch = (state == FETCH_ENC);

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op <= OP_WR_REG) begin
            w_state    = S_ACCESS;
            w_wait     = '0;
            w_is_mem   = ~cmd_op[1];
            w_is_write = cmd_op[0];
            if (!cmd_op[1]) begin
              w_memop   = 1'b1;
              w_memaddr = cmd_addr;
              if (cmd_op[0]) begin
                w_memwr    = 1'b1;
                w_memwdata = cmd_data;
              end
            end else begin
              w_regop   = 1'b1;
              w_regaddr = cmd_addr[RAW-1:0];
              if (cmd_op[0]) begin
                w_regwr    = 1'b1;
                w_regwdata = cmd_data;
              end
            end
          end else if (cmd_op == OP_RUN) begin
            w_state     = S_RUN_RST;
            w_dut_reset = 1'b1;
            w_resetpc   = cmd_addr;
            w_remaining = {1'b0, cmd_count} + 17'd1;
            w_timeout   = cmd_timeout;
          end else begin
            w_state      = S_RESP;
            w_rsp_data   = '0;
            w_rsp_status = ST_ILLEGAL;
          end
        end
      end
      S_ACCESS: begin
        if (r_wait == WAIT_LAST) begin
          w_state      = S_RESP;
          w_rsp_data   = w_sample;
          w_rsp_status = (r_is_write && (w_sample != (r_is_mem ? r_memwdata : r_regwdata)))
                         ? ST_VERIFY : ST_OK;
          w_memop      = 1'b0;
          w_regop      = 1'b0;
          w_memwr      = 1'b0;
          w_regwr      = 1'b0;
        end else begin
          w_wait = r_wait + WCW'(1);
        end
      end
      S_RUN_RST: begin
        // A fetch already present in the first RUN cycle must count as an edge.
        w_state      = S_RUN;
        w_test       = 1'b1;
        w_cycle      = '0;
        w_prev_fetch = 1'b0;
      end
      S_RUN: begin
        w_cycle = r_cycle + TW'(1);
        if (w_fetch) w_remaining = r_remaining - 17'd1;
        if (w_fetch && (r_remaining == 17'd1)) begin
          w_state      = S_RESP;
          w_test       = 1'b0;
          w_rsp_data   = PC;
          w_rsp_status = ST_OK;
        end else if ((r_timeout != '0) && (r_cycle == r_timeout)) begin
          w_state      = S_RESP;
          w_test       = 1'b0;
          w_rsp_data   = PC;
          w_rsp_status = ST_TIMEOUT;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_is_mem     <= 1'b0;
      r_is_write   <= 1'b0;
      r_wait       <= '0;
      r_remaining  <= '0;
      r_cycle      <= '0;
      r_timeout    <= '0;
      r_prev_fetch <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
      r_dut_reset  <= 1'b0;
      r_test       <= 1'b0;
      r_memop      <= 1'b0;
      r_regop      <= 1'b0;
      r_memwr      <= 1'b0;
      r_regwr      <= 1'b0;
      r_memaddr    <= '0;
      r_memwdata   <= '0;
      r_resetpc    <= '0;
      r_regaddr    <= '0;
      r_regwdata   <= '0;
    end else begin
      r_state      <= w_state;
      r_is_mem     <= w_is_mem;
      r_is_write   <= w_is_write;
      r_wait       <= w_wait;
      r_remaining  <= w_remaining;
      r_cycle      <= w_cycle;
      r_timeout    <= w_timeout;
      r_prev_fetch <= w_prev_fetch;
      r_cmd_ready  <= (w_state == S_IDLE);
      r_rsp_valid  <= (w_state == S_RESP);
      r_rsp_data   <= w_rsp_data;
      r_rsp_status <= w_rsp_status;
      r_dut_reset  <= w_dut_reset;
      r_test       <= w_test;
      r_memop      <= w_memop;
      r_regop      <= w_regop;
      r_memwr      <= w_memwr;
      r_regwr      <= w_regwr;
      r_memaddr    <= w_memaddr;
      r_memwdata   <= w_memwdata;
      r_resetpc    <= w_resetpc;
      r_regaddr    <= w_regaddr;
      r_regwdata   <= w_regwdata;
    end
  end

  assign cmd_ready         = r_cmd_ready;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_data          = r_rsp_data;
  assign rsp_status        = r_rsp_status;
  assign dut_reset         = r_dut_reset;
  assign test              = r_test;
  assign memoryoperation   = r_memop;
  assign registeroperation = r_regop;
  assign memorywrite       = r_memwr;
  assign registerwrite     = r_regwr;
  assign memaddress        = r_memaddr;
  assign memwritedata      = r_memwdata;
  assign resetpc           = r_resetpc;
  assign registeraddress   = r_regaddr;
  assign regwritedata      = r_regwdata;

endmodule

// File: tb/tb_debug_access_sequencer.sv
// Testbench for debug_access_sequencer: SystemTest stand-in (memory, registers, toy CPU)
// plus a scoreboard and an analytic RUN model.
module tb_debug_access_sequencer;

  localparam logic [2:0] OP_RD_MEM = 3'd0;
  localparam logic [2:0] OP_WR_MEM = 3'd1;
  localparam logic [2:0] OP_RD_REG = 3'd2;
  localparam logic [2:0] OP_WR_REG = 3'd3;
  localparam logic [2:0] OP_RUN    = 3'd4;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr, cmd_data, cmd_count, cmd_timeout;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        dut_reset, test, memoryoperation, registeroperation, memorywrite, registerwrite;
  logic [15:0] memaddress, memwritedata, resetpc, regwritedata;
  logic [3:0]  registeraddress;
  logic [15:0] RD, MD, PC;
  logic [8:0]  state;

  always #5 clk = ~clk;

  debug_access_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_timeout(cmd_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .dut_reset(dut_reset), .test(test), .memoryoperation(memoryoperation),
    .registeroperation(registeroperation), .memorywrite(memorywrite), .registerwrite(registerwrite),
    .memaddress(memaddress), .memwritedata(memwritedata), .resetpc(resetpc),
    .registeraddress(registeraddress), .regwritedata(regwritedata),
    .RD(RD), .MD(MD), .PC(PC), .state(state)
  );

  // SystemTest stand-in: fetch every 'period' test cycles; opcode F = jr Rn, else pc+1.
  logic [15:0] mem [64];
  logic [15:0] regs [16];
  int          cpu_c;
  logic [15:0] cpu_pc;
  int          period = 3;
  logic        stuck = 1'b0, md_zero = 1'b0, tb_init = 1'b1;

  function automatic logic [15:0] model_step(input logic [15:0] pc);
    logic [15:0] ins;
    ins = mem[pc[5:0]];
    return (ins[15:12] == 4'hF) ? regs[ins[3:0]] : pc + 16'd1;
  endfunction

  assign MD    = md_zero ? 16'h0 : mem[memaddress[5:0]];
  assign RD    = regs[registeraddress];
  assign PC    = cpu_pc;
  assign state = !test ? 9'd0 : (stuck || (cpu_c % period) != 0) ? 9'd2 : 9'd1;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      cpu_c  <= 0;
      cpu_pc <= '0;
    end else begin
      if (memorywrite) mem[memaddress[5:0]] <= memwritedata;
      if (registerwrite) regs[registeraddress] <= regwritedata;
      if (dut_reset) begin
        cpu_c  <= 0;
        cpu_pc <= resetpc;
      end else if (test) begin
        cpu_c <= cpu_c + 1;
        if (!stuck && (cpu_c % period) == period - 1) cpu_pc <= model_step(cpu_pc);
      end
    end
  end

  logic excl_viol = 1'b0;
  always @(negedge clk) begin
    if ((int'(memoryoperation) + int'(registeroperation) + int'(test)) > 1) excl_viol <= 1'b1;
    if ((memorywrite && !memoryoperation) || (registerwrite && !registeroperation)) excl_viol <= 1'b1;
  end

  // Scoreboard and checking
  int          checks = 0, errors = 0;
  logic [15:0] sb_mem [64];
  logic [15:0] sb_reg [16];
  logic [15:0] o_data, seen_pc;
  logic [1:0]  o_stat;
  int          o_lat, n_memop, n_regop, n_memwr, n_regwr, n_test, n_dutrst, n_fetch;
  logic        o_got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exec_n(input logic [15:0] pc0, input int n);
    logic [15:0] pc, ins;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      ins = sb_mem[pc[5:0]];
      pc  = (ins[15:12] == 4'hF) ? sb_reg[ins[3:0]] : pc + 16'd1;
    end
    return pc;
  endfunction

  // Issue one command, observe strobes until the response, optionally stall rsp_ready, then accept it.
  task automatic send(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] data,
                      input logic [15:0] cnt, input logic [15:0] tmo, input int hold);
    int   n;
    logic prev_f, stable, blocked;
    n_memop = 0; n_regop = 0; n_memwr = 0; n_regwr = 0; n_test = 0; n_dutrst = 0; n_fetch = 0;
    seen_pc = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    cmd_count = cnt; cmd_timeout = tmo;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    o_lat = 1;
    prev_f = 1'b0;
    while (1) begin
      n_memop += int'(memoryoperation);
      n_regop += int'(registeroperation);
      n_memwr += int'(memorywrite);
      n_regwr += int'(registerwrite);
      n_test  += int'(test);
      if (dut_reset) begin n_dutrst++; seen_pc = resetpc; end
      if (state == 9'd1 && !prev_f) n_fetch++;
      prev_f = (state == 9'd1);
      if (rsp_valid || o_lat >= 300) break;
      @(negedge clk);
      o_lat++;
    end
    o_got = rsp_valid;
    chk("rsp_arrives", 32'(o_got), 32'd1);
    o_data = rsp_data;
    o_stat = rsp_status;
    if (hold > 0) begin
      stable = 1'b1; blocked = 1'b1;
      cmd_valid = 1'b1; cmd_op = OP_RD_MEM;
      repeat (hold) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== o_data || rsp_status !== o_stat) stable = 1'b0;
        if (cmd_ready !== 1'b0) blocked = 1'b0;
      end
      cmd_valid = 1'b0;
      chk("rsp_stable_while_stalled", 32'(stable), 32'd1);
      chk("cmd_blocked_while_stalled", 32'(blocked), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_transfer", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after_transfer", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_chk(input logic [15:0] start, input int cnt, input int tmo, input int per);
    int          done_idx, end_idx;
    logic [1:0]  es;
    logic [15:0] epc;
    period   = per;
    done_idx = cnt * per;
    if (tmo != 0 && tmo < done_idx) begin end_idx = tmo; es = 2'd2; end
    else begin end_idx = done_idx; es = 2'd0; end
    epc = exec_n(start, end_idx / per);
    send(OP_RUN, start, 16'h0, 16'(cnt), 16'(tmo), 0);
    chk("run_status", 32'(o_stat), 32'(es));
    chk("run_final_pc", 32'(o_data), 32'(epc));
    chk("run_test_cycles", n_test, end_idx + 1);
    chk("run_fetch_events", n_fetch, end_idx / per + 1);
    chk("run_latency", o_lat, end_idx + 3);
    chk("run_dut_reset_cycles", n_dutrst, 1);
    chk("run_resetpc", 32'(seen_pc), 32'(start));
    chk("run_no_access", n_memop + n_regop, 0);
  endtask

  task automatic wr_mem(input logic [5:0] a, input logic [15:0] d);
    send(OP_WR_MEM, {10'd0, a}, d, 16'h0, 16'h0, 0);
    sb_mem[a] = d;
    chk("wr_mem_status", 32'(o_stat), 32'd0);
    chk("wr_mem_readback", 32'(o_data), 32'(d));
    chk("wr_mem_strobe_cycles", n_memwr, WAITC);
  endtask

  task automatic wr_reg(input logic [3:0] r, input logic [15:0] d);
    send(OP_WR_REG, {12'd0, r}, d, 16'h0, 16'h0, 0);
    sb_reg[r] = d;
    chk("wr_reg_status", 32'(o_stat), 32'd0);
    chk("wr_reg_readback", 32'(o_data), 32'(d));
    chk("wr_reg_strobe_cycles", n_regwr, WAITC);
    chk("wr_reg_no_mem", n_memop, 0);
  endtask

  logic        saw_rsp, lost_ready;
  logic [5:0]  ra;
  logic [3:0]  rr;
  logic [15:0] rd16;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    cmd_count = '0; cmd_timeout = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) sb_mem[i] = '0;
    for (int i = 0; i < 16; i++) sb_reg[i] = '0;
    repeat (3) @(negedge clk);
    tb_init = 1'b0;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_test", 32'(test), 32'd0);
    chk("reset_dut_reset", 32'(dut_reset), 32'd0);
    chk("reset_memop", 32'(memoryoperation), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    reset = 1'b0;

    wr_mem(6'd3, 16'hEE02);
    chk("wr_latency", o_lat, WAITC + 1);
    chk("wr_memop_cycles", n_memop, WAITC);
    send(OP_RD_MEM, 16'd3, 16'h0, 16'h0, 16'h0, 0);
    chk("rd_mem_status", 32'(o_stat), 32'd0);
    chk("rd_mem_data", 32'(o_data), 32'hEE02);
    chk("rd_latency", o_lat, WAITC + 1);
    chk("rd_no_write_strobe", n_memwr, 0);

    wr_reg(4'd0, 16'd11);
    wr_mem(6'd3, 16'hF000);
    run_chk(16'd3, 1, 0, 3);
    chk("jr_final_pc", 32'(o_data), 32'd11);
    chk("jr_fetch_events", n_fetch, 2);

    md_zero = 1'b1;
    send(OP_WR_MEM, 16'd5, 16'h1234, 16'h0, 16'h0, 0);
    md_zero = 1'b0;
    sb_mem[5] = 16'h1234;
    chk("verify_fail_status", 32'(o_stat), 32'd1);
    chk("verify_fail_data", 32'(o_data), 32'd0);

    stuck = 1'b1;
    send(OP_RUN, 16'd8, 16'h0, 16'd1, 16'd5, 0);
    stuck = 1'b0;
    chk("timeout_status", 32'(o_stat), 32'd2);
    chk("timeout_test_cycles", n_test, 6);
    chk("timeout_pc", 32'(o_data), 32'd8);
    chk("timeout_no_fetch", n_fetch, 0);

    for (int op = 5; op < 8; op++) begin
      send(3'(op), 16'd7, 16'hFFFF, 16'h0, 16'h0, (op == 7) ? 4 : 0);
      chk("illegal_status", 32'(o_stat), 32'd3);
      chk("illegal_data", 32'(o_data), 32'd0);
      chk("illegal_latency", o_lat, 1);
      chk("illegal_no_strobes", n_memop + n_regop + n_test + n_dutrst, 0);
    end
    send(OP_RD_MEM, 16'd5, 16'h0, 16'h0, 16'h0, 4);
    chk("stalled_rd_data", 32'(o_data), 32'h1234);

    for (int it = 0; it < 8; it++) begin
      ra = 6'($urandom_range(0, 63));
      wr_mem(ra, 16'($urandom));
      ra = 6'($urandom_range(0, 63));
      send(OP_RD_MEM, {10'd0, ra}, 16'h0, 16'h0, 16'h0, 0);
      chk("rand_rd_mem", 32'(o_data), 32'(sb_mem[ra]));
      rr = 4'($urandom_range(0, 15));
      wr_reg(rr, 16'($urandom_range(0, 63)));
      rr = 4'($urandom_range(0, 15));
      send(OP_RD_REG, {12'd0, rr}, 16'h0, 16'h0, 16'h0, 0);
      chk("rand_rd_reg", 32'(o_data), 32'(sb_reg[rr]));
      chk("rand_rd_reg_status", 32'(o_stat), 32'd0);
      rd16 = 16'($urandom_range(0, 63));
      run_chk(rd16, $urandom_range(0, 6),
              ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30), $urandom_range(2, 4));
    end

    // Reset during an access
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_RD_MEM; cmd_addr = 16'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_abort_access_memop", 32'(memoryoperation), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_access_memop", 32'(memoryoperation), 32'd0);
    chk("abort_access_test", 32'(test), 32'd0);
    chk("abort_access_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    saw_rsp = 1'b0; lost_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
      if (!cmd_ready) lost_ready = 1'b1;
    end
    chk("abort_access_no_rsp", 32'(saw_rsp), 32'd0);
    chk("abort_access_ready_held", 32'(lost_ready), 32'd0);

    // Reset during a RUN
    period = 4;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_addr = 16'd0; cmd_count = 16'd20; cmd_timeout = 16'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_run_test", 32'(test), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_run_test", 32'(test), 32'd0);
    chk("abort_run_dut_reset", 32'(dut_reset), 32'd0);
    chk("abort_run_memaddress", 32'(memaddress), 32'd0);
    chk("abort_run_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_rsp = 1'b0; lost_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || test) saw_rsp = 1'b1;
      if (!cmd_ready) lost_ready = 1'b1;
    end
    chk("abort_run_no_rsp", 32'(saw_rsp), 32'd0);
    chk("abort_run_ready_held", 32'(lost_ready), 32'd0);

    chk("strobe_exclusion", 32'(excl_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
